// File: rtl/ip_seq_unit_if.sv
// Control/status bundle between decode/control and the instruction-pointer sequencer.
// The master drives the op request; the slave returns the IP, the return stack state and the error flags.
interface ip_seq_unit_if #(
    parameter int W     = 8,
    parameter int LEN_W = 3,
    parameter int REL_W = 8,
    parameter int DEPTH = 4
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic             en_i;
    logic [2:0]       op_i;
    logic [LEN_W-1:0] len_i;
    logic [W-1:0]     d_i;
    logic [REL_W-1:0] rel_i;
    logic             clr_err_i;

    logic [W-1:0]     ip_o;
    logic [W-1:0]     seq_ip_o;
    logic [SP_W-1:0]  sp_o;
    logic             stk_full_o;
    logic             stk_empt_o;
    logic             err_ovf_o;
    logic             err_unf_o;

    modport master (
        output en_i, op_i, len_i, d_i, rel_i, clr_err_i,
        input  ip_o, seq_ip_o, sp_o, stk_full_o, stk_empt_o, err_ovf_o, err_unf_o
    );

    modport slave (
        input  en_i, op_i, len_i, d_i, rel_i, clr_err_i,
        output ip_o, seq_ip_o, sp_o, stk_full_o, stk_empt_o, err_ovf_o, err_unf_o
    );
endinterface

// File: rtl/ip_seq_unit.sv
// Instruction-pointer sequencer: variable-length advance, absolute/relative jumps
// and a return-address stack for CALL/RET, with sticky overflow/underflow flags.
module ip_seq_unit #(
    parameter int             W         = 8,
    parameter int             LEN_W     = 3,
    parameter int             REL_W     = 8,
    parameter int             DEPTH     = 4,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    ip_seq_unit_if.slave bus
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_INC   = 3'b001,
        OP_LOAD  = 3'b010,
        OP_JREL  = 3'b011,
        OP_CALL  = 3'b100,
        OP_CALLR = 3'b101,
        OP_RET   = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    logic [W-1:0]      ip_q, ip_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;
    logic [W-1:0]      stk_q [DEPTH];

    logic [W-1:0]      seq_ip;
    logic [W-1:0]      tgt_rel;
    logic signed [REL_W-1:0] rel_s;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              stk_full;
    logic              stk_empt;
    logic              push;
    logic              new_ovf;
    logic              new_unf;
    op_e               op;

    assign op       = op_e'(bus.op_i);
    assign rel_s    = bus.rel_i;
    assign seq_ip   = ip_q + W'(bus.len_i);
    assign tgt_rel  = seq_ip + W'(rel_s);
    assign stk_full = (sp_q == SP_W'(DEPTH));
    assign stk_empt = (sp_q == '0);
    assign wr_idx   = sp_q[IDX_W-1:0];
    assign rd_idx   = wr_idx - IDX_W'(1);

    always_comb begin
        ip_d    = ip_q;
        sp_d    = sp_q;
        push    = 1'b0;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (bus.en_i) begin
            case (op)
                OP_INC:  ip_d = seq_ip;
                OP_LOAD: ip_d = bus.d_i;
                OP_JREL: ip_d = tgt_rel;
                OP_CALL, OP_CALLR: begin
                    // The jump is taken even when the push has to be dropped.
                    ip_d = (op == OP_CALL) ? bus.d_i : tgt_rel;
                    if (stk_full) begin
                        new_ovf = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (stk_empt) begin
                        new_unf = 1'b1;
                    end else begin
                        ip_d = stk_q[rd_idx];
                        sp_d = sp_q - SP_W'(1);
                    end
                end
                default: ;
            endcase
        end
        err_ovf_d = (err_ovf_q & ~bus.clr_err_i) | new_ovf;
        err_unf_d = (err_unf_q & ~bus.clr_err_i) | new_unf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_q      <= RESET_VAL;
            sp_q      <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            ip_q      <= ip_d;
            sp_q      <= sp_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Stack storage carries no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stk_q[wr_idx] <= seq_ip;
        end
    end

    assign bus.ip_o       = ip_q;
    assign bus.seq_ip_o   = seq_ip;
    assign bus.sp_o       = sp_q;
    assign bus.stk_full_o = stk_full;
    assign bus.stk_empt_o = stk_empt;
    assign bus.err_ovf_o  = err_ovf_q;
    assign bus.err_unf_o  = err_unf_q;
endmodule

// File: tb/tb_ip_seq_unit.sv
// Bench for ip_seq_unit: directed scenarios with literal expectations, then random ops,
// all checked every cycle against a queue-based model of the IP and return stack.
module tb_ip_seq_unit;
    localparam int W     = 8;
    localparam int LEN_W = 3;
    localparam int REL_W = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_on = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    int m_ip = 0;
    int m_stk[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    ip_seq_unit_if #(.W(W), .LEN_W(LEN_W), .REL_W(REL_W), .DEPTH(DEPTH)) bus ();

    ip_seq_unit #(
        .W(W), .LEN_W(LEN_W), .REL_W(REL_W), .DEPTH(DEPTH), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ip = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit en, input int op, input int len, input int d,
                              input int rel_s, input bit clr);
        int seq;
        int tgt;
        bit novf;
        bit nunf;
        novf = 1'b0;
        nunf = 1'b0;
        seq = (m_ip + len) & 255;
        tgt = (seq + rel_s) & 255;
        if (en) begin
            case (op)
                1: m_ip = seq;
                2: m_ip = d;
                3: m_ip = tgt;
                4, 5: begin
                    if (m_stk.size() == DEPTH) novf = 1'b1;
                    else m_stk.push_back(seq);
                    m_ip = (op == 4) ? d : tgt;
                end
                6: begin
                    if (m_stk.size() == 0) nunf = 1'b1;
                    else m_ip = m_stk.pop_back();
                end
                default: ;
            endcase
        end
        m_ovf = (m_ovf && !clr) || novf;
        m_unf = (m_unf && !clr) || nunf;
    endtask

    // Inputs change at posedge+2; the model advances at posedge+1 using the held inputs.
    task automatic step(input bit en, input int op, input int len, input int d,
                        input int rel, input bit clr);
        logic [7:0]        rel8;
        logic signed [7:0] rel_sv;
        int                rel_i;
        rel8   = rel[7:0];
        rel_sv = rel8;
        rel_i  = rel_sv;
        bus.en_i      = en;
        bus.op_i      = op[2:0];
        bus.len_i     = len[2:0];
        bus.d_i       = d[7:0];
        bus.rel_i     = rel8;
        bus.clr_err_i = clr;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_step(en, op & 7, len & 7, d & 255, rel_i, clr);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ip",       bus.ip_o,       m_ip);
            chk("seq_ip",   bus.seq_ip_o,   (m_ip + int'(bus.len_i)) & 255);
            chk("sp",       bus.sp_o,       m_stk.size());
            chk("stk_full", bus.stk_full_o, (m_stk.size() == DEPTH) ? 1 : 0);
            chk("stk_empt", bus.stk_empt_o, (m_stk.size() == 0) ? 1 : 0);
            chk("err_ovf",  bus.err_ovf_o,  m_ovf);
            chk("err_unf",  bus.err_unf_o,  m_unf);
        end
    end

    initial begin
        int ret_exp[4];
        ret_exp = '{32'h41, 32'h31, 32'h21, 32'h13};
        bus.en_i = 1'b0; bus.op_i = '0; bus.len_i = '0;
        bus.d_i = '0; bus.rel_i = '0; bus.clr_err_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_ip", bus.ip_o, 32'h00);
        chk("rst_sp", bus.sp_o, 0);

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 2, 0, 0, 0);
            chk("inc_ip", bus.ip_o, 2 * (i + 1));
        end
        step(0, 1, 2, 0, 0, 0);
        chk("en0_hold", bus.ip_o, 32'h06);

        step(1, 2, 0, 'hFE, 0, 0);
        step(1, 1, 3, 0, 0, 0);
        chk("wrap_inc", bus.ip_o, 32'h01);
        step(1, 2, 0, 'h02, 0, 0);
        step(1, 3, 1, 0, 'hF9, 0);
        chk("wrap_jrel", bus.ip_o, 32'hFC);

        step(1, 2, 0, 'h10, 0, 0);
        step(1, 4, 2, 'h40, 0, 0);
        chk("call_ip", bus.ip_o, 32'h40);
        chk("call_sp", bus.sp_o, 1);
        step(1, 5, 1, 0, 'h10, 0);
        chk("callr_ip", bus.ip_o, 32'h51);
        chk("callr_sp", bus.sp_o, 2);
        step(1, 6, 0, 0, 0, 0);
        chk("ret1_ip", bus.ip_o, 32'h41);
        step(1, 6, 0, 0, 0, 0);
        chk("ret2_ip", bus.ip_o, 32'h12);
        chk("ret2_sp", bus.sp_o, 0);

        for (int i = 0; i < 5; i++) step(1, 4, 1, 'h20 + 16 * i, 0, 0);
        chk("ovf_ip", bus.ip_o, 32'h60);
        chk("ovf_sp", bus.sp_o, 4);
        chk("ovf_full", bus.stk_full_o, 1);
        chk("ovf_flag", bus.err_ovf_o, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 6, 0, 0, 0, 0);
            chk("lifo_ip", bus.ip_o, ret_exp[i]);
        end
        step(1, 6, 0, 0, 0, 0);
        chk("unf_ip", bus.ip_o, 32'h13);
        chk("unf_flag", bus.err_unf_o, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("clr_ovf", bus.err_ovf_o, 0);
        chk("clr_unf", bus.err_unf_o, 0);
        step(1, 6, 0, 0, 0, 1);
        chk("set_wins", bus.err_unf_o, 1);

        step(1, 4, 1, 'h10, 0, 0);
        step(1, 4, 1, 'h20, 0, 0);
        step(1, 4, 1, 'h77, 0, 0);
        chk("pre_rst_sp", bus.sp_o, 3);
        chk("pre_rst_ip", bus.ip_o, 32'h77);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_ip", bus.ip_o, 32'h00);
        chk("arst_sp", bus.sp_o, 0);
        chk("arst_unf", bus.err_unf_o, 0);
        chk("arst_empt", bus.stk_empt_o, 1);
        step(1, 4, 1, 'h55, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            int op;
            int r;
            r = $urandom_range(0, 15);
            if (r < 4) op = 4 + (r & 1);
            else if (r < 8) op = 6;
            else op = $urandom_range(0, 7);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                step(1, op, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), 0);
                rst = 1'b0;
            end else begin
                step(($urandom_range(0, 9) != 0), op, $urandom_range(0, 7),
                     $urandom_range(0, 255), $urandom_range(0, 255),
                     ($urandom_range(0, 7) == 0));
            end
        end

        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
